// File: rtl/spi_pkg.sv
// Shared constants, command codes and FSM state encoding for the SPI master.
package spi_pkg;

    localparam int WORD_W       = 10;
    localparam int DATA_W       = 8;
    localparam int FRAME_WR_LEN = 12;
    localparam int FRAME_RD_LEN = 22;
    localparam int TURN_CYCLES  = 2;
    localparam int GAP_CYCLES   = 2;
    localparam int K_W          = 5;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Last frame-cycle index of each phase; k restarts from 0 on entry to GAP.
    localparam logic [K_W-1:0] K_WR_LAST   = K_W'(FRAME_WR_LEN - 1);
    localparam logic [K_W-1:0] K_TURN_LAST = K_W'(FRAME_WR_LEN + TURN_CYCLES - 1);
    localparam logic [K_W-1:0] K_RD_LAST   = K_W'(FRAME_RD_LEN - 1);
    localparam logic [K_W-1:0] K_GAP_LAST  = K_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD,
        SHIFT,
        TURN,
        RECV,
        GAP
    } state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// Shift path: 10-bit load/shift-out word register (MSB first) and 8-bit shift-in register.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_out_i,
    input  logic              shift_in_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              miso_i,
    output logic              tx_msb_o,
    output logic [DATA_W-1:0] rx_next_o
);

    logic [WORD_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;

    assign tx_msb_o  = tx_q[WORD_W-1];
    assign rx_next_o = {rx_q[DATA_W-2:0], miso_i};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (load_i) begin
            tx_d = word_i;
        end else if (shift_out_i) begin
            tx_d = {tx_q[WORD_W-2:0], 1'b0};
        end
        if (shift_in_i) begin
            rx_d = rx_next_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master framing FSM: 12-cycle write frames, 22-cycle read-data frames, 2-cycle deselect gap.
// Optional read-order enforcement (refuse out-of-order reads, pulse err) with SPI_MASTER_RD_ORDER_EN.
module spi_master
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);

    state_e            state_q;
    logic [K_W-1:0]    k_q;
    logic [1:0]        cmd_q;
    logic              ss_n_q, mosi_q, busy_q, done_q, rdata_valid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept, refuse, wr_last, rd_last, tx_msb;
    logic [DATA_W-1:0] rx_next;

    assign wr_last = (state_q == SHIFT) && (k_q == K_WR_LAST);
    assign rd_last = (state_q == RECV) && (k_q == K_RD_LAST);
    assign accept  = (state_q == IDLE) && start && !refuse;

`ifdef SPI_MASTER_RD_ORDER_EN
    // Flag set means an address has been sent and a read-data frame is now due.
    logic rd_order_q, err_q;

    assign refuse = ((cmd == CMD_RD_DATA) && !rd_order_q) ||
                    ((cmd == CMD_RD_ADDR) && rd_order_q);
    assign err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_order_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && start && refuse;
            if (wr_last && (cmd_q == CMD_RD_ADDR)) begin
                rd_order_q <= 1'b1;
            end else if (rd_last) begin
                rd_order_q <= 1'b0;
            end
        end
    end
`else
    assign refuse = 1'b0;
    assign err    = 1'b0;
`endif

    spi_master_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .shift_out_i ((state_q == CMD) || (state_q == SHIFT)),
        .shift_in_i  (state_q == RECV),
        .word_i      ({cmd, din}),
        .miso_i      (miso),
        .tx_msb_o    (tx_msb),
        .rx_next_o   (rx_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            cmd_q         <= CMD_WR_ADDR;
            ss_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            rdata_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= START;
                        cmd_q   <= cmd;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        ss_n_q  <= 1'b0;
                        mosi_q  <= 1'b0;
                    end
                end
                START, CMD: begin
                    // cmd[1] is presented at k=1 and again as the word MSB at k=2.
                    state_q <= (state_q == START) ? CMD : SHIFT;
                    mosi_q  <= tx_msb;
                    k_q     <= k_q + 1'b1;
                end
                SHIFT: begin
                    if (!wr_last) begin
                        mosi_q <= tx_msb;
                        k_q    <= k_q + 1'b1;
                    end else if (cmd_q == CMD_RD_DATA) begin
                        state_q <= TURN;
                        mosi_q  <= 1'b0;
                        k_q     <= k_q + 1'b1;
                    end else begin
                        state_q <= GAP;
                        mosi_q  <= 1'b0;
                        ss_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        k_q     <= '0;
                    end
                end
                TURN: begin
                    if (k_q == K_TURN_LAST) begin
                        state_q <= RECV;
                    end
                    k_q <= k_q + 1'b1;
                end
                RECV: begin
                    if (rd_last) begin
                        state_q       <= GAP;
                        ss_n_q        <= 1'b1;
                        done_q        <= 1'b1;
                        rdata_q       <= rx_next;
                        rdata_valid_q <= 1'b1;
                        k_q           <= '0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                GAP: begin
                    if (k_q == K_GAP_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign ss_n        = ss_n_q;
    assign mosi        = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: per-cycle frame model, behavioural SPI slave with RAM, random traffic.
module tb_spi_master;

`ifdef SPI_MASTER_RD_ORDER_EN
    localparam bit RD_ORDER_EN = 1'b1;
`else
    localparam bit RD_ORDER_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, miso;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       busy, done, rdata_valid, err, ss_n, mosi;
    logic [7:0] rdata;

    spi_master dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cmd         (cmd),
        .din         (din),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (driven by the intended commands).
    logic [7:0] ref_mem [256];
    logic [7:0] ref_addr;
    logic       ref_flag;
    logic [7:0] exp_rdata;
    // Slave model state (driven by the bits actually seen on mosi).
    logic [7:0] slv_mem [256];
    logic [7:0] slv_addr;

    // Per-frame observations.
    logic [10:0] obs_seq;
    int obs_busy, obs_done_cnt, obs_done_k, obs_valid_k, obs_err_cnt, obs_ss_low;

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_flag  = 1'b0;
        exp_rdata = 8'h00;
        @(negedge clk);
    endtask

    // Runs one request from a negedge; returns at the negedge of the first idle cycle.
    task automatic do_frame(input logic [1:0] c, input logic [7:0] d, input int drop_at, input int abort_at);
        logic [9:0] word;
        logic [9:0] slv_word;
        logic [7:0] ret_byte;
        logic [7:0] o [7];
        logic [7:0] e [7];
        string nm [7];
        bit refused;
        int len, blen, last_k;
        nm = '{"ss_n", "mosi", "busy", "done", "rdata_valid", "err", "rdata"};
        word     = {c, d};
        slv_word = '0;
        ret_byte = '0;
        refused  = RD_ORDER_EN && (((c == 2'b11) && !ref_flag) || ((c == 2'b10) && ref_flag));
        len      = (c == 2'b11) ? 22 : 12;
        blen     = refused ? 0 : len + 2;
        last_k   = refused ? 3 : blen;
        obs_seq = '0; obs_busy = 0; obs_done_cnt = 0; obs_done_k = -1;
        obs_valid_k = -1; obs_err_cnt = 0; obs_ss_low = 0;

        start = 1'b1; cmd = c; din = d;
        @(negedge clk);
        start = 1'b0; cmd = 2'($urandom); din = 8'($urandom);

        for (int k = 0; k <= last_k; k++) begin
            miso = (k >= 14 && k <= 21) ? ret_byte[21-k] : 1'($urandom);
            if (!refused && c == 2'b11 && k == len) exp_rdata = ref_mem[ref_addr];
            o = '{8'(ss_n), 8'(mosi), 8'(busy), 8'(done), 8'(rdata_valid), 8'(err), rdata};
            e[0] = 8'(refused || k >= len);
            e[1] = (refused || k == 0 || k > 11) ? 8'd0 : (k == 1) ? 8'(c[1]) : 8'(word[11-k]);
            e[2] = 8'(!refused && k < blen);
            e[3] = 8'(!refused && k == len);
            e[4] = 8'(!refused && c == 2'b11 && k == len);
            e[5] = 8'(refused && k == 0);
            e[6] = exp_rdata;
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (o[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL frame cmd=%b din=%h k=%0d %s: got %h expected %h", c, d, k, nm[i], o[i], e[i]);
                end
            end
            // Slave model: capture word from mosi, act on it when the write portion ends.
            if (!ss_n && k >= 2 && k <= 11) slv_word[11-k] = mosi;
            if (!refused && k == 12) begin
                case (slv_word[9:8])
                    2'b00, 2'b10: slv_addr = slv_word[7:0];
                    2'b01:        slv_mem[slv_addr] = slv_word[7:0];
                    default:      ret_byte = slv_mem[slv_addr];
                endcase
            end
            if (k >= 1 && k <= 11) obs_seq = {obs_seq[9:0], mosi};
            if (busy) obs_busy++;
            if (done) begin obs_done_cnt++; obs_done_k = k; end
            if (rdata_valid) obs_valid_k = k;
            if (err) obs_err_cnt++;
            if (!ss_n) obs_ss_low++;
            if (k == drop_at) begin
                start = 1'b1; cmd = 2'($urandom); din = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                for (int j = 0; j < 4; j++) begin
                    n_checks++;
                    if (ss_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rdata !== 8'h00) begin
                        n_fail++;
                        $display("FAIL abort step %0d: got ss_n=%b busy=%b done=%b rdata=%h expected 1 0 0 00",
                                 j, ss_n, busy, done, rdata);
                    end
                    @(negedge clk);
                    rst = 1'b0;
                end
                ref_flag  = 1'b0;
                exp_rdata = 8'h00;
                return;
            end
            if (k < last_k) @(negedge clk);
        end

        if (!refused) begin
            case (c)
                2'b00:   ref_addr = d;
                2'b01:   ref_mem[ref_addr] = d;
                2'b10:   begin ref_addr = d; ref_flag = 1'b1; end
                default: ref_flag = 1'b0;
            endcase
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({ss_n, mosi, busy, done, rdata_valid, err, rdata} !== {6'b100000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: got ss_n=%b mosi=%b busy=%b done=%b rv=%b err=%b rdata=%h expected 1 0 0 0 0 0 00",
                     ss_n, mosi, busy, done, rdata_valid, err, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ss_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ss_n=%b busy=%b expected 1 0", ss_n, busy);
        end
    endtask

    task automatic test_write_addr();
        do_frame(2'b00, 8'hA5, -1, -1);
        n_checks++;
        if (obs_seq !== 11'b000_1010_0101) begin
            n_fail++;
            $display("FAIL wr_addr_mosi: got %b expected 00010100101", obs_seq);
        end
        n_checks++;
        if (obs_busy != 14 || obs_done_cnt != 1 || obs_done_k != 12) begin
            n_fail++;
            $display("FAIL wr_addr_timing: got busy=%0d dones=%0d done_k=%0d expected 14 1 12",
                     obs_busy, obs_done_cnt, obs_done_k);
        end
    endtask

    task automatic test_read_pair();
        ref_mem[8'h3C] = 8'hC3;
        slv_mem[8'h3C] = 8'hC3;
        do_frame(2'b10, 8'h3C, -1, -1);
        do_frame(2'b11, 8'($urandom), -1, -1);
        n_checks++;
        if (rdata !== 8'hC3 || obs_valid_k != 22 || obs_busy != 24) begin
            n_fail++;
            $display("FAIL read_pair: got rdata=%h valid_k=%0d busy=%0d expected C3 22 24",
                     rdata, obs_valid_k, obs_busy);
        end
    endtask

    task automatic test_busy_drop();
        do_frame(2'b01, 8'($urandom), 4, -1);
        n_checks++;
        if (obs_done_cnt != 1 || obs_busy != 14) begin
            n_fail++;
            $display("FAIL busy_drop: got dones=%0d busy=%0d expected 1 14", obs_done_cnt, obs_busy);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (ss_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_drop_idle: got ss_n=%b busy=%b done=%b expected 1 0 0", ss_n, busy, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_frame(2'b10, 8'($urandom), -1, -1);
        do_frame(2'b11, 8'($urandom), -1, 6);
        n_checks++;
        if (obs_done_cnt != 0 || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got dones=%0d rdata=%h expected 0 00", obs_done_cnt, rdata);
        end
    endtask

    task automatic test_rd_order();
        pulse_reset();
        do_frame(2'b11, 8'h5A, -1, -1);
`ifdef SPI_MASTER_RD_ORDER_EN
        n_checks++;
        if (obs_err_cnt != 1 || obs_ss_low != 0) begin
            n_fail++;
            $display("FAIL rd_order_refuse: got errs=%0d ss_low=%0d expected 1 0", obs_err_cnt, obs_ss_low);
        end
`else
        n_checks++;
        if (obs_err_cnt != 0 || obs_busy != 24) begin
            n_fail++;
            $display("FAIL rd_order_accept: got errs=%0d busy=%0d expected 0 24", obs_err_cnt, obs_busy);
        end
`endif
    endtask

    task automatic test_end_to_end();
        do_frame(2'b00, 8'h20, -1, -1);
        do_frame(2'b01, 8'h10, -1, -1);
        do_frame(2'b10, 8'h20, -1, -1);
        do_frame(2'b11, 8'($urandom), -1, -1);
        n_checks++;
        if (rdata !== 8'h10) begin
            n_fail++;
            $display("FAIL end_to_end: got rdata=%h expected 10", rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            do_frame(2'($urandom), 8'($urandom), -1, -1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd = 2'b00; din = 8'h00; miso = 1'b0;
        ref_flag = 1'b0; exp_rdata = 8'h00; ref_addr = 8'h00; slv_addr = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            slv_mem[i] = ref_mem[i];
        end
        test_reset();
        test_write_addr();
        test_read_pair();
        test_busy_drop();
        test_reset_mid();
        test_rd_order();
        test_end_to_end();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge; same clock as the SPI slave.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request strobe; sampled only while busy=0.
REQ-005 SHALL have port cmd, input, 2 bits: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-006 SHALL have port din, input, 8 bits: payload (address or write data); dummy for read-data.
REQ-007 SHALL have port busy, output, 1 bit: frame in progress; requests are ignored while high.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-009 SHALL have port rdata, output, 8 bits: last byte read back; held until the next read-data frame.
REQ-010 SHALL have port rdata_valid, output, 1 bit: one-cycle pulse when rdata updates.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse for a refused request (see REQ-030).
REQ-012 SHALL have ports ss_n, output, 1 bit (active-low select); mosi, output, 1 bit; miso, input, 1 bit.

Function
REQ-013 SHALL drive ss_n and mosi from registers only.
REQ-014 SHALL, on start=1 with busy=0, capture word = {cmd, din} (10 bits) and raise busy on the next cycle.
REQ-015 SHALL define frame cycle k=0 as the first cycle with ss_n=0.
REQ-016 SHALL drive mosi=0 at k=0, mosi=cmd[1] at k=1, and mosi=word[11-k] for k=2..11 (MSB first).
REQ-017 SHALL drive mosi=0 for all k>=12 and while idle.
REQ-018 SHALL, for cmd 00/01/10, hold ss_n=0 for k=0..11 and drive ss_n=1 at k=12.
REQ-019 SHALL, for cmd 11, hold ss_n=0 for k=0..21 and drive ss_n=1 at k=22.
REQ-020 SHALL, for cmd 11, ignore miso at k=12..13 (turnaround) and shift miso in MSB first at the clock edges ending k=14..21 (bit 7 first).
REQ-021 SHALL use states IDLE, START (k=0), CMD (k=1), SHIFT (k=2..11), TURN (k=12..13, cmd 11 only), RECV (k=14..21), GAP.
REQ-022 SHALL make the transitions SHIFT->GAP for cmd 00/01/10, SHIFT->TURN->RECV->GAP for cmd 11, and GAP->IDLE after exactly 2 cycles.
REQ-023 SHALL keep ss_n=1 throughout GAP, guaranteeing at least 2 deselected cycles between frames.
REQ-024 SHALL pulse done in the first GAP cycle; for cmd 11, SHALL update rdata and pulse rdata_valid in that same cycle.
REQ-025 SHALL hold busy=1 from the cycle after acceptance through the last GAP cycle: 14 cycles for cmd 00/01/10, 24 cycles for cmd 11.
REQ-026 SHALL drop start pulses that arrive while busy=1, with no queuing and no err.
REQ-027 SHALL accept a new start in the cycle busy returns to 0 (back-to-back frames).

Reset
REQ-028 SHALL, while rst=1, immediately force ss_n=1, mosi=0, busy=0, done=0, rdata=8'h00, rdata_valid=0, err=0, state=IDLE, and the read-order flag=0.
REQ-029 SHALL abort any frame on reset mid-frame with no done pulse, and SHALL start the next frame only on a fresh start after rst=0.

Configuration
REQ-030 SHALL, with SPI_MASTER_RD_ORDER_EN defined, keep a flag that is set by a completed cmd 10 and cleared by a completed cmd 11.
REQ-031 SHALL, with SPI_MASTER_RD_ORDER_EN defined, refuse cmd 11 when the flag is 0 and cmd 10 when the flag is 1: no frame, busy stays 0, err pulses 1 cycle after start.
REQ-032 SHALL, without SPI_MASTER_RD_ORDER_EN, accept all requests, tie err to 0, and omit the flag.

Structure
REQ-033 SHALL take from shared package spi_pkg: the command codes (CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11), WORD_W=10, DATA_W=8, the frame-length constants (12, 22), TURN_CYCLES=2, and the state enum.
REQ-034 SHALL place the shift path in one sub-module, spi_master_shifter: a 10-bit load/shift-out register plus an 8-bit shift-in register, controlled by the FSM.

Verification
REQ-035 SHALL verify write-address: start, cmd=00, din=8'hA5 -> mosi at k=1..11 = 0,0,0,1,0,1,0,0,1,0,1; ss_n high at k=12; done at k=12; busy for 14 cycles.
REQ-036 SHALL verify read pair: cmd=10, din=8'h3C, then cmd=11, with a slave model returning 8'hC3 -> rdata=8'hC3, rdata_valid at k=22, and cmd-11 busy for 24 cycles.
REQ-037 SHALL verify busy drop: start pulsed at the 5th busy cycle of a write -> no second frame, exactly one done.
REQ-038 SHALL verify reset mid-frame: rst=1 at k=6 of a cmd-11 frame -> ss_n=1 and busy=0 in that cycle, no done, rdata stays 8'h00.
REQ-039 SHALL verify read ordering with SPI_MASTER_RD_ORDER_EN: cmd=11 after reset -> err pulse, ss_n never low; without the macro -> frame runs and err stays 0.
REQ-040 SHALL verify end-to-end traffic against spi_slave+RAM: 8'h10 written to address 8'h20 via cmd 00/01, then read back via cmd 10/11 -> rdata=8'h10.
